// File: rtl/edge_stage_sequencer.sv
// edge_stage_sequencer
//   Runs the six edge-detector stages in a fixed order: gaussian, conv, sobel,
//   non-max suppress, threshold, hysteresis. Each stage is enabled in turn.
//   The sequencer waits for that stage's done and inserts one idle gap cycle
//   before the next stage. A stage that runs too long, a lost input frame, or
//   a dropped run request ends the sequence.
//
// Ports
//   clk             rising-edge system clock
//   reset_n         asynchronous active-low reset
//   enable          run request (level); low aborts a run or clears DONE/ERROR
//   image_in_valid  input frame present; must stay high for the whole run
//   stage_done      per-stage done (level); only the current stage is observed
//   stage_enable    one-hot (or zero) enable for the current stage
//   image_out_valid high while the whole sequence has completed (DONE)
//   busy            high while a stage runs or during the inter-stage gap
//   progress        sticky per-stage completion flags, cleared on a new start
//   error           high while in ERROR
//   error_code      00 none, 01 stage timeout, 10 input lost
//   error_stage     stage index active when the error was raised
module edge_stage_sequencer #(
  parameter int NUM_STAGES     = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W          = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  image_in_valid,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic                  image_out_valid,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] progress,
  output logic                  error,
  output logic [1:0]            error_code,
  output logic [IDX_W-1:0]      error_stage
);

  localparam int                CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX       = IDX_W'(NUM_STAGES - 1);
  localparam logic [1:0]        ERR_TIMEOUT    = 2'b01;
  localparam logic [1:0]        ERR_INPUT_LOST = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             done_seen;

  // The first RUN cycle (cnt == 0) masks done so a level left over from the
  // previous frame or stage cannot complete the new stage immediately.
  always_comb begin
    done_seen = 1'b0;
    if (cnt != '0) begin
      done_seen = stage_done[idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      cnt             <= '0;
      stage_enable    <= '0;
      image_out_valid <= 1'b0;
      busy            <= 1'b0;
      progress        <= '0;
      error           <= 1'b0;
      error_code      <= '0;
      error_stage     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable && image_in_valid) begin
            state        <= S_RUN;
            idx          <= '0;
            cnt          <= '0;
            progress     <= '0;
            stage_enable <= NUM_STAGES'(1);
            busy         <= 1'b1;
          end
        end

        // RUN and GAP share the abort / input-lost handling so the priority
        // order (abort, input lost, done, timeout) lives in one place.
        S_RUN, S_GAP: begin
          if (!enable) begin
            state        <= S_IDLE;
            idx          <= '0;
            stage_enable <= '0;
            busy         <= 1'b0;
          end else if (!image_in_valid) begin
            state        <= S_ERROR;
            stage_enable <= '0;
            busy         <= 1'b0;
            error        <= 1'b1;
            error_code   <= ERR_INPUT_LOST;
            error_stage  <= idx;
          end else if (state == S_GAP) begin
            state        <= S_RUN;
            idx          <= idx + IDX_W'(1);
            cnt          <= '0;
            stage_enable <= NUM_STAGES'(1) << (idx + IDX_W'(1));
          end else if (done_seen) begin
            progress[idx] <= 1'b1;
            stage_enable  <= '0;
            if (idx == LAST_IDX) begin
              state           <= S_DONE;
              busy            <= 1'b0;
              image_out_valid <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else if (cnt == CNT_LIMIT) begin
            state        <= S_ERROR;
            stage_enable <= '0;
            busy         <= 1'b0;
            error        <= 1'b1;
            error_code   <= ERR_TIMEOUT;
            error_stage  <= idx;
          end else begin
            // Only reached below the limit, so the counter can never wrap.
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          if (!enable) begin
            state           <= S_IDLE;
            idx             <= '0;
            image_out_valid <= 1'b0;
          end
        end

        S_ERROR: begin
          if (!enable) begin
            state       <= S_IDLE;
            idx         <= '0;
            error       <= 1'b0;
            error_code  <= '0;
            error_stage <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Testbench for edge_stage_sequencer. Stage responders raise done a fixed
// number of cycles after their enable rises. The expected output trace of a
// whole run is built up front from stage durations. Each stage is RUN for
// max(latency,2) cycles, followed by one gap, or by a timeout after limit+1 RUN
// cycles. This trace is then compared against the DUT every cycle.
module tb_edge_stage_sequencer;

  localparam int NS = 6;
  localparam int TO = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          image_in_valid;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_enable;
  logic          image_out_valid;
  logic          busy;
  logic [NS-1:0] progress;
  logic          error;
  logic [1:0]    error_code;
  logic [IW-1:0] error_stage;
  logic [31:0]   act;

  always #5 clk = ~clk;

  edge_stage_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .image_in_valid (image_in_valid),
    .stage_done     (stage_done),
    .stage_enable   (stage_enable),
    .image_out_valid(image_out_valid),
    .busy           (busy),
    .progress       (progress),
    .error          (error),
    .error_code     (error_code),
    .error_stage    (error_stage)
  );

  // {enable[19:14], busy[13], out_valid[12], error[11], code[10:9], stage[8:6], progress[5:0]}
  assign act = {12'b0, stage_enable, busy, image_out_valid, error, error_code, error_stage, progress};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [19:0] ent(input logic [5:0] en, input logic b, input logic ov,
                                      input logic er, input logic [1:0] code,
                                      input logic [2:0] es, input logic [5:0] p);
    return {en, b, ov, er, code, es, p};
  endfunction

  int          lat[NS];   // done latency per stage; 0 = never completes
  logic [19:0] tr[$];
  int          tr_stage[$];

  task automatic set_lat(input int a, input int b, input int c, input int d, input int e, input int f);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d; lat[4] = e; lat[5] = f;
  endtask

  // Expected per-cycle outputs after the start edge, ending with the terminal
  // (DONE or timeout ERROR) entry.
  task automatic build();
    logic [5:0] p;
    p = '0;
    tr.delete();
    tr_stage.delete();
    for (int s = 0; s < NS; s++) begin
      logic [5:0] oh;
      int n;
      oh = 6'(1) << s;
      if (lat[s] == 0) begin
        for (int k = 0; k <= TO; k++) begin
          tr.push_back(ent(oh, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, p));
          tr_stage.push_back(s);
        end
        tr.push_back(ent(6'd0, 1'b0, 1'b0, 1'b1, 2'b01, 3'(s), p));
        tr_stage.push_back(s);
        return;
      end
      n = (lat[s] < 2) ? 2 : lat[s];
      repeat (n) begin
        tr.push_back(ent(oh, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, p));
        tr_stage.push_back(s);
      end
      p[s] = 1'b1;
      if (s < NS - 1) tr.push_back(ent(6'd0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, p));
      else            tr.push_back(ent(6'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0, p));
      tr_stage.push_back(s);
    end
  endtask

  // mode: 0 normal, 1 abort, 2 input lost, 3 async reset.
  // Event at first RUN cycle of evt_stage plus evt_off, or random if evt_stage < 0.
  task automatic run_scen(input string name, input bit stale, input bit noise, input int mode,
                          input int evt_stage, input int evt_off, input int hold);
    int cnt[NS];
    int evt, last;
    bit stop;
    logic [31:0] idle_exp;
    build();
    evt = -1;
    if (mode != 0) begin
      if (evt_stage >= 0) begin
        for (int i = tr.size() - 1; i >= 0; i--)
          if (tr_stage[i] == evt_stage && tr[i][19:14] != 6'd0) evt = i;
        evt = evt + evt_off;
      end else begin
        evt = $urandom_range(0, tr.size() - 2);
      end
      while (tr.size() > evt + 1) begin
        void'(tr.pop_back());
        void'(tr_stage.pop_back());
      end
      if (mode == 1) tr.push_back(ent(6'd0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, tr[evt][5:0]));
      if (mode == 2) tr.push_back(ent(6'd0, 1'b0, 1'b0, 1'b1, 2'b10, 3'(tr_stage[evt]), tr[evt][5:0]));
    end
    last = tr.size() - 1;
    foreach (cnt[i]) cnt[i] = 0;

    @(negedge clk);
    enable         = 1'b1;
    image_in_valid = 1'b1;
    stage_done     = stale ? '1 : '0;
    stop = 1'b0;
    for (int j = 0; j <= last + hold && !stop; j++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, j), act, {12'b0, tr[(j < last) ? j : last]});
      check($sformatf("%s_inv%0d", name, j),
            {29'b0, $onehot0(stage_enable), (!image_out_valid || (&progress)),
             ((int'(busy) + int'(image_out_valid) + int'(error)) <= 1)}, 32'd7);
      for (int s = 0; s < NS; s++) begin
        cnt[s] = stage_enable[s] ? cnt[s] + 1 : 0;
        stage_done[s] = stale || (lat[s] != 0 && cnt[s] >= lat[s]) ||
                        (noise && !stage_enable[s] && $urandom_range(0, 1) == 1);
      end
      if (j == evt) begin
        case (mode)
          1: enable = 1'b0;
          2: image_in_valid = 1'b0;
          3: begin
            #1 reset_n = 1'b0;
            #1 check($sformatf("%s_async_reset", name), act, 32'd0);
            stop = 1'b1;
          end
          default: ;
        endcase
      end
    end
    if (mode == 3) begin
      @(negedge clk);
      reset_n = 1'b1;
    end
    idle_exp = (mode == 3) ? 32'd0 : {26'b0, tr[last][5:0]};
    enable         = 1'b0;
    image_in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("%s_idle", name), act, idle_exp);
  endtask

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b0;
    image_in_valid = 1'b0;
    stage_done     = '0;
    repeat (2) @(negedge clk);
    check("reset_state", act, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", act, 32'd0);

    set_lat(3, 5, 2, 4, 1, 6);
    run_scen("nominal", 1'b0, 1'b0, 0, -1, 0, 3);
    run_scen("restart", 1'b0, 1'b0, 0, -1, 0, 2);
    set_lat(1, 1, 1, 1, 1, 1);
    run_scen("stale", 1'b1, 1'b0, 0, -1, 0, 1);
    set_lat(3, 5, 2, 4, 1, 6);
    run_scen("foreign", 1'b0, 1'b1, 0, -1, 0, 1);
    set_lat(2, 2, 2, 0, 2, 2);
    run_scen("timeout", 1'b0, 1'b0, 0, -1, 0, 3);
    set_lat(TO + 1, 2, 3, 2, 2, 2);
    run_scen("done_at_limit", 1'b0, 1'b0, 0, -1, 0, 1);
    set_lat(3, 5, 4, 4, 1, 6);
    run_scen("input_lost", 1'b0, 1'b0, 2, 2, 1, 2);
    set_lat(3, 5, 2, 4, 5, 6);
    run_scen("abort", 1'b0, 1'b0, 1, 4, 2, 2);
    set_lat(3, 5, 2, 4, 1, 6);
    run_scen("reset_mid", 1'b0, 1'b0, 3, 1, 1, 0);

    for (int r = 0; r < 25; r++) begin
      bit st, nz;
      int md, pick;
      st = ($urandom_range(0, 5) == 0);
      nz = ($urandom_range(0, 1) == 1);
      for (int s = 0; s < NS; s++) lat[s] = $urandom_range(1, 6);
      pick = $urandom_range(0, 7);
      if (pick == 0)      lat[$urandom_range(0, NS - 1)] = 0;
      else if (pick == 1) lat[$urandom_range(0, NS - 1)] = TO + 1;
      if (st) for (int s = 0; s < NS; s++) lat[s] = 1;
      md = $urandom_range(0, 2);
      run_scen($sformatf("rnd%0d", r), st, nz, md, -1, 0, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
